sub_writeback: RTL and testbench

Downstream writeback stage for the vector SUB engine. It consumes the packed int8 result beats (`MAX_VECTOR_SIZE` lanes per beat, valid-only, no backpressure) and writes them into the word-addressed output buffer starting at a programmed base address. It counts elements against a programmed total and byte-masks the partial tail beat. It signals completion with a one-cycle `done` pulse and flags beats that arrive when no job is active.

---
 rtl/sub_writeback.sv | 191 +++++++++++++++++++
 tb/tb_sub_writeback.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sub_writeback.sv
// sub_writeback: writeback stage for the vector SUB engine.
// Takes packed int8 result beats (valid-only, no backpressure) and writes
// them to a word-addressed output buffer from a programmed base address.
// It counts elements against a programmed total and byte-masks the partial
// tail beat. It pulses done on completion and flags beats dropped outside
// RUN.
// Optional feature: define SUB_WB_CHECKSUM_EN to add the checksum output.
// That output is a running sum of the sign-extended enabled lanes.
module sub_writeback #(
  parameter int MAX_VECTOR_SIZE = 8,
  parameter int ADDR_WIDTH      = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [31:0]                  num_elements,
  input  logic                         valid_in,
  input  logic [8*MAX_VECTOR_SIZE-1:0] data_in,
  output logic                         mem_we,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [8*MAX_VECTOR_SIZE-1:0] mem_wdata,
  output logic [MAX_VECTOR_SIZE-1:0]   mem_be,
  output logic                         busy,
  output logic                         done,
`ifdef SUB_WB_CHECKSUM_EN
  output logic [31:0]                  checksum,
`endif
  output logic                         overrun
);

  localparam logic [31:0] LP_LANES = 32'(MAX_VECTOR_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t                       r_state;
  logic [ADDR_WIDTH-1:0]        r_wr_addr;
  logic [31:0]                  r_remaining;
  logic                         r_mem_we;
  logic [ADDR_WIDTH-1:0]        r_mem_addr;
  logic [8*MAX_VECTOR_SIZE-1:0] r_mem_wdata;
  logic [MAX_VECTOR_SIZE-1:0]   r_mem_be;
  logic                         r_busy;
  logic                         r_done;
  logic                         r_overrun;

  state_t                       w_state_next;
  logic                         w_start;
  logic                         w_accept;
  logic                         w_drop;
  logic [31:0]                  w_consume;
  logic [31:0]                  w_rem_next;
  logic [MAX_VECTOR_SIZE-1:0]   w_be;

  // Lane i is enabled while more than i elements remain; this yields all
  // ones for a full beat and the low 'remaining' bits for the tail beat.
  always_comb begin
    for (int i = 0; i < MAX_VECTOR_SIZE; i++) begin
      w_be[i] = (r_remaining > 32'(i));
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    w_state_next = r_state;
    w_start      = 1'b0;
    w_accept     = 1'b0;
    w_drop       = valid_in && (r_state != ST_RUN);
    w_consume    = (r_remaining >= LP_LANES) ? LP_LANES : r_remaining;
    w_rem_next   = r_remaining - w_consume;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_start      = 1'b1;
          w_state_next = (num_elements == 32'd0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (valid_in) begin
          w_accept = 1'b1;
          if (w_rem_next == 32'd0) begin
            w_state_next = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register plus job bookkeeping (address and element counter).
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wr_addr   <= '0;
      r_remaining <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_wr_addr   <= base_addr;
        r_remaining <= num_elements;
      end else if (w_accept) begin
        r_wr_addr   <= r_wr_addr + 1'b1;
        r_remaining <= w_rem_next;
      end
    end
  end

  // Registered buffer write port; a reset suppresses any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else begin
      r_mem_we <= w_accept;
      if (w_accept) begin
        r_mem_addr  <= r_wr_addr;
        r_mem_wdata <= data_in;
        r_mem_be    <= w_be;
      end
    end
  end

  // Registered status: busy and done track the state being entered.
  // A beat dropped on the start cycle wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_busy <= (w_state_next == ST_RUN);
      r_done <= (w_state_next == ST_FIN);
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (w_start) begin
        r_overrun <= 1'b0;
      end
    end
  end

`ifdef SUB_WB_CHECKSUM_EN
  logic [31:0] r_checksum;
  logic [31:0] w_beat_sum;

  // Sum of the sign-extended int8 values in the enabled lanes of this beat.
  always_comb begin
    w_beat_sum = 32'd0;
    for (int i = 0; i < MAX_VECTOR_SIZE; i++) begin
      if (w_be[i]) begin
        w_beat_sum = w_beat_sum + {{24{data_in[i*8+7]}}, data_in[i*8 +: 8]};
      end
    end
  end

  // Checksum accumulator; cleared by an accepted start, wraps modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_checksum <= 32'd0;
    end else if (w_start) begin
      r_checksum <= 32'd0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + w_beat_sum;
    end
  end

  assign checksum = r_checksum;
`endif

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_sub_writeback.sv
// Directed testbench for sub_writeback.
// Inputs change 1 ns after a rising edge, and outputs are sampled at that
// same point. After tick(), the outputs therefore reflect the edge just taken.
module tb_sub_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] base_addr;
  logic [31:0] num_elements;
  logic        valid_in;
  logic [63:0] data_in;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_be;
  logic        busy;
  logic        done;
  logic        overrun;
`ifdef SUB_WB_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sub_writeback #(.MAX_VECTOR_SIZE(8), .ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_elements(num_elements), .valid_in(valid_in), .data_in(data_in),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .busy(busy), .done(done),
`ifdef SUB_WB_CHECKSUM_EN
    .checksum(checksum),
`endif
    .overrun(overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; num_elements = '0;
    valid_in = 1'b0; data_in = '0;
    tick(); tick();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", mem_we); end
    checks++; if (mem_addr !== 12'h000) begin errors++; $display("FAIL reset_addr got %h exp 000", mem_addr); end
    checks++; if (mem_wdata !== 64'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", mem_wdata); end
    checks++; if (mem_be !== 8'h00) begin errors++; $display("FAIL reset_be got %h exp 00", mem_be); end
    checks++; if ({busy, done, overrun} !== 3'b000) begin errors++; $display("FAIL reset_status got %b exp 000", {busy, done, overrun}); end
`ifdef SUB_WB_CHECKSUM_EN
    checks++; if (checksum !== 32'd0) begin errors++; $display("FAIL reset_checksum got %h exp 0", checksum); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_beats();
    start = 1'b1; base_addr = 12'h010; num_elements = 32'd16;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy got %b exp 1", busy); end
    valid_in = 1'b1; data_in = 64'h0706050403020100;
    tick();
    data_in = 64'h0f0e0d0c0b0a0908;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 12'h010) begin errors++; $display("FAIL full_wr0 got we=%b addr=%h exp we=1 addr=010", mem_we, mem_addr); end
    checks++; if (mem_wdata !== 64'h0706050403020100 || mem_be !== 8'hFF) begin errors++; $display("FAIL full_data0 got %h be=%h exp 0706050403020100 be=ff", mem_wdata, mem_be); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_early_done got %b exp 0", done); end
    tick();
    valid_in = 1'b0;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 12'h011 || mem_be !== 8'hFF) begin errors++; $display("FAIL full_wr1 got we=%b addr=%h be=%h exp we=1 addr=011 be=ff", mem_we, mem_addr, mem_be); end
    checks++; if (mem_wdata !== 64'h0f0e0d0c0b0a0908) begin errors++; $display("FAIL full_data1 got %h exp 0f0e0d0c0b0a0908", mem_wdata); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL full_done got done=%b busy=%b exp done=1 busy=0", done, busy); end
    tick();
    checks++; if (done !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL full_after got done=%b we=%b exp 0 0", done, mem_we); end
  endtask

  task automatic test_partial_tail();
    start = 1'b1; base_addr = 12'h020; num_elements = 32'd13;
    tick();
    start = 1'b0; valid_in = 1'b1; data_in = 64'h1111111111111111;
    tick();
    data_in = 64'h2222222222222222;
    checks++; if (mem_be !== 8'hFF || mem_addr !== 12'h020) begin errors++; $display("FAIL tail_wr0 got be=%h addr=%h exp be=ff addr=020", mem_be, mem_addr); end
    tick();
    valid_in = 1'b0;
    checks++; if (mem_we !== 1'b1 || mem_be !== 8'h1F || mem_addr !== 12'h021) begin errors++; $display("FAIL tail_wr1 got we=%b be=%h addr=%h exp we=1 be=1f addr=021", mem_we, mem_be, mem_addr); end
    checks++; if (mem_wdata !== 64'h2222222222222222) begin errors++; $display("FAIL tail_data got %h exp 2222222222222222", mem_wdata); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL tail_done got %b exp 1", done); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL tail_after got busy=%b done=%b exp 0 0", busy, done); end
  endtask

  task automatic test_empty_job();
    int we_seen;
    start = 1'b1; base_addr = 12'h030; num_elements = 32'd0;
    tick();
    start = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL empty_done got done=%b busy=%b we=%b exp 1 0 0", done, busy, mem_we); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL empty_pulse got %b exp 0", done); end
    valid_in = 1'b1; data_in = 64'hdeadbeefdeadbeef;
    tick();
    valid_in = 1'b0;
    we_seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_we) we_seen++;
      tick();
    end
    checks++; if (we_seen != 0) begin errors++; $display("FAIL empty_nowrite got %0d writes exp 0", we_seen); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL empty_overrun got %b exp 1", overrun); end
  endtask

  task automatic test_addr_wrap();
    start = 1'b1; base_addr = 12'hFFF; num_elements = 32'd24;
    tick();
    start = 1'b0;
    checks++; if (overrun !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wrap_start got overrun=%b busy=%b exp 0 1", overrun, busy); end
    valid_in = 1'b1; data_in = 64'hA0A0A0A0A0A0A0A0;
    tick();
    valid_in = 1'b0;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 12'hFFF) begin errors++; $display("FAIL wrap_wr0 got we=%b addr=%h exp 1 fff", mem_we, mem_addr); end
    tick();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL wrap_gap got we=%b exp 0", mem_we); end
    start = 1'b1; base_addr = 12'h123; num_elements = 32'd8;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL wrap_ignore_start got busy=%b done=%b exp 1 0", busy, done); end
    valid_in = 1'b1; data_in = 64'hB1B1B1B1B1B1B1B1;
    tick();
    valid_in = 1'b0;
    checks++; if (mem_addr !== 12'h000 || done !== 1'b0) begin errors++; $display("FAIL wrap_wr1 got addr=%h done=%b exp 000 0", mem_addr, done); end
    tick();
    valid_in = 1'b1; data_in = 64'hC2C2C2C2C2C2C2C2;
    tick();
    valid_in = 1'b0;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 12'h001 || mem_be !== 8'hFF || done !== 1'b1) begin errors++; $display("FAIL wrap_wr2 got we=%b addr=%h be=%h done=%b exp 1 001 ff 1", mem_we, mem_addr, mem_be, done); end
    tick();
  endtask

  task automatic test_reset_mid_job();
    start = 1'b1; base_addr = 12'h040; num_elements = 32'd24;
    tick();
    start = 1'b0; valid_in = 1'b1; data_in = 64'h0102030405060708;
    tick();
    checks++; if (mem_addr !== 12'h040 || mem_we !== 1'b1) begin errors++; $display("FAIL rstmid_wr0 got addr=%h we=%b exp 040 1", mem_addr, mem_we); end
    rst = 1'b1; data_in = 64'h1112131415161718;
    tick();
    rst = 1'b0; valid_in = 1'b0;
    checks++; if ({mem_we, busy, done, overrun} !== 4'b0000 || mem_addr !== 12'h000 || mem_be !== 8'h00 || mem_wdata !== 64'h0) begin errors++; $display("FAIL rstmid_outputs got we=%b busy=%b done=%b ovr=%b addr=%h be=%h exp all 0", mem_we, busy, done, overrun, mem_addr, mem_be); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_nodone got done=%b busy=%b we=%b exp 0 0 0", done, busy, mem_we); end
    start = 1'b1; base_addr = 12'h050; num_elements = 32'd8;
    tick();
    start = 1'b0; valid_in = 1'b1; data_in = 64'h8877665544332211;
    tick();
    valid_in = 1'b0;
    checks++; if (mem_addr !== 12'h050 || mem_be !== 8'hFF || mem_wdata !== 64'h8877665544332211 || done !== 1'b1) begin errors++; $display("FAIL rstmid_fresh got addr=%h be=%h data=%h done=%b exp 050 ff 8877665544332211 1", mem_addr, mem_be, mem_wdata, done); end
    tick();
  endtask

  task automatic test_start_with_drop();
    start = 1'b1; valid_in = 1'b1; base_addr = 12'h060; num_elements = 32'd3;
    data_in = 64'hFFFFFFFFFFFFFFFF;
    tick();
    start = 1'b0;
    checks++; if (overrun !== 1'b1 || busy !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL drop_start got ovr=%b busy=%b we=%b exp 1 1 0", overrun, busy, mem_we); end
    data_in = 64'h0000000000030201;
    tick();
    valid_in = 1'b0;
    checks++; if (mem_addr !== 12'h060 || mem_be !== 8'h07 || done !== 1'b1) begin errors++; $display("FAIL drop_tail got addr=%h be=%h done=%b exp 060 07 1", mem_addr, mem_be, done); end
    tick();
  endtask

`ifdef SUB_WB_CHECKSUM_EN
  task automatic test_checksum();
    start = 1'b1; base_addr = 12'h070; num_elements = 32'd10;
    tick();
    start = 1'b0;
    checks++; if (checksum !== 32'd0) begin errors++; $display("FAIL csum_clear got %h exp 0", checksum); end
    valid_in = 1'b1; data_in = 64'hFFFFFFFFFFFFFFFF;
    tick();
    data_in = 64'h555555555555027F;
    tick();
    valid_in = 1'b0;
    checks++; if (mem_be !== 8'h03 || done !== 1'b1) begin errors++; $display("FAIL csum_tail got be=%h done=%b exp 03 1", mem_be, done); end
    checks++; if (checksum !== 32'd121) begin errors++; $display("FAIL csum_value got %0d exp 121", checksum); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_full_beats();
    test_partial_tail();
    test_empty_job();
    test_addr_wrap();
    test_reset_mid_job();
    test_start_with_drop();
`ifdef SUB_WB_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
